apb_bridge_reg: RTL and testbench

Registered, timeout-protected APB bridge: the next-generation replacement for the combinational APB bridge on the peripheral bus. It captures each master transfer, decodes it against NUM_SLAVES base/mask windows, and replays it on a fully registered slave side. It returns the response with added wait states and terminates hung slaves with PSLVERR after a programmable timeout. A runtime enable mask and sticky error status feed the system error controller.

---
 rtl/apb_bridge_reg.sv | 169 ++++++++++++++++
 tb/tb_apb_bridge_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_reg.sv
// Registered APB bridge: captures a master transfer, decodes it against base/mask
// windows, replays it on a registered slave side and bounds slave stalls with a timeout.
module apb_bridge_reg #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] BASE_ADDR =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] ADDR_MASK =
        {32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  pclk,
    input  logic                                  presetn,
    input  logic [ADDR_WIDTH-1:0]                 paddr,
    input  logic                                  psel,
    input  logic                                  penable,
    input  logic                                  pwrite,
    input  logic [DATA_WIDTH-1:0]                 pwdata,
    input  logic [DATA_WIDTH/8-1:0]               pstrb,
    input  logic [2:0]                            pprot,
    output logic [DATA_WIDTH-1:0]                 prdata,
    output logic                                  pready,
    output logic                                  pslverr,
    output logic [ADDR_WIDTH-1:0]                 paddr_s,
    output logic [NUM_SLAVES-1:0]                 psel_s,
    output logic                                  penable_s,
    output logic                                  pwrite_s,
    output logic [DATA_WIDTH-1:0]                 pwdata_s,
    output logic [DATA_WIDTH/8-1:0]               pstrb_s,
    output logic [2:0]                            pprot_s,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] prdata_s,
    input  logic [NUM_SLAVES-1:0]                 pready_s,
    input  logic [NUM_SLAVES-1:0]                 pslverr_s,
    input  logic [NUM_SLAVES-1:0]                 slave_en,
    input  logic                                  err_clr,
    output logic                                  decerr_flag,
    output logic                                  timeout_flag,
    output logic [3:0]                            err_slave
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]            state;
    logic [SEL_W-1:0]      sel;
    logic [CNT_W-1:0]      cnt;
    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic [ADDR_WIDTH-1:0] hit_off;
    logic                  setup_req;
    logic                  to_hit;
    logic                  set_dec;
    logic                  set_to;

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (((paddr & ~ADDR_MASK[k]) == (BASE_ADDR[k] & ~ADDR_MASK[k])) && slave_en[k]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
                hit_off = paddr & ADDR_MASK[k];
            end
        end
    end

    assign setup_req = (state == IDLE) && psel && !penable;
    assign to_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign set_dec   = setup_req && !hit;
    assign set_to    = (state == ACCESS) && !pready_s[sel] && to_hit;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            sel       <= '0;
            cnt       <= '0;
            prdata    <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            paddr_s   <= '0;
            psel_s    <= '0;
            penable_s <= 1'b0;
            pwrite_s  <= 1'b0;
            pwdata_s  <= '0;
            pstrb_s   <= '0;
            pprot_s   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup_req) begin
                        paddr_s  <= hit_off;
                        pwrite_s <= pwrite;
                        pwdata_s <= pwdata;
                        pstrb_s  <= pstrb;
                        pprot_s  <= pprot;
                        if (hit) begin
                            sel    <= hit_idx;
                            psel_s <= NUM_SLAVES'(1) << hit_idx;
                            state  <= SETUP;
                        end else begin
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            prdata  <= '0;
                            state   <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_s <= 1'b1;
                    cnt       <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (pready_s[sel]) begin
                        psel_s    <= '0;
                        penable_s <= 1'b0;
                        pready    <= 1'b1;
                        pslverr   <= pslverr_s[sel];
                        prdata    <= pwrite_s ? '0 : prdata_s[sel];
                        state     <= RESP;
                    end else if (to_hit) begin
                        psel_s    <= '0;
                        penable_s <= 1'b0;
                        pready    <= 1'b1;
                        pslverr   <= 1'b1;
                        prdata    <= '0;
                        state     <= RESP;
                    end
                end
                default: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Clearing wins over a flag event landing on the same edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            decerr_flag  <= 1'b0;
            timeout_flag <= 1'b0;
            err_slave    <= '0;
        end else if (err_clr) begin
            decerr_flag  <= 1'b0;
            timeout_flag <= 1'b0;
            err_slave    <= '0;
        end else begin
            if (set_dec) decerr_flag <= 1'b1;
            if (set_to) begin
                timeout_flag <= 1'b1;
                err_slave    <= 4'(sel);
            end
        end
    end

endmodule

// File: tb/tb_apb_bridge_reg.sv
// Randomized bench for apb_bridge_reg against a cycle-count reference model.
module tb_apb_bridge_reg;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 8;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic [AW-1:0] paddr;
    logic psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0] pprot;
    logic [DW-1:0] prdata;
    logic pready, pslverr;
    logic [AW-1:0] paddr_s;
    logic [NS-1:0] psel_s;
    logic penable_s, pwrite_s;
    logic [DW-1:0] pwdata_s;
    logic [DW/8-1:0] pstrb_s;
    logic [2:0] pprot_s;
    logic [NS-1:0][DW-1:0] prdata_s;
    logic [NS-1:0] pready_s, pslverr_s, slave_en;
    logic err_clr;
    logic decerr_flag, timeout_flag;
    logic [3:0] err_slave;

    // second instance with overlapping windows (slave 1 spans 0x0000-0x1FFF)
    logic [DW-1:0] prdata2;
    logic pready2, pslverr2;
    logic [AW-1:0] paddr_s2;
    logic [NS-1:0] psel_s2, pready_s2;
    logic penable_s2, pwrite_s2;
    logic [DW-1:0] pwdata_s2;
    logic [DW/8-1:0] pstrb_s2;
    logic [2:0] pprot_s2;
    logic decerr2, timeout2;
    logic [3:0] err_slave2;

    apb_bridge_reg #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .paddr_s(paddr_s), .psel_s(psel_s),
        .penable_s(penable_s), .pwrite_s(pwrite_s), .pwdata_s(pwdata_s), .pstrb_s(pstrb_s),
        .pprot_s(pprot_s), .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s),
        .slave_en(slave_en), .err_clr(err_clr), .decerr_flag(decerr_flag),
        .timeout_flag(timeout_flag), .err_slave(err_slave));

    apb_bridge_reg #(.ADDR_MASK({32'h0FFF, 32'h0FFF, 32'h1FFF, 32'h0FFF})) dut_ovl (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata2),
        .pready(pready2), .pslverr(pslverr2), .paddr_s(paddr_s2), .psel_s(psel_s2),
        .penable_s(penable_s2), .pwrite_s(pwrite_s2), .pwdata_s(pwdata_s2), .pstrb_s(pstrb_s2),
        .pprot_s(pprot_s2), .prdata_s(prdata_s), .pready_s(pready_s2), .pslverr_s('0),
        .slave_en(slave_en), .err_clr(err_clr), .decerr_flag(decerr2),
        .timeout_flag(timeout2), .err_slave(err_slave2));

    assign pready_s2 = penable_s2 ? psel_s2 : '0;

    // slave model: answers after wait_cfg stalled ACCESS cycles
    int wait_cfg = 0;
    int acc_cyc;
    logic serr_cfg = 1'b0;
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) acc_cyc <= 0;
        else if (penable_s && psel_s != '0 && pready_s == '0) acc_cyc <= acc_cyc + 1;
        else acc_cyc <= 0;
    end
    assign pready_s  = (penable_s && acc_cyc == wait_cfg) ? psel_s : '0;
    assign pslverr_s = serr_cfg ? pready_s : '0;

    int n_chk = 0;
    int n_err = 0;
    bit m_dec, m_to;
    int m_es;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_prdata"}, 64'(prdata), 0);
        chk({tag, "_ctl"}, 64'({pready, pslverr, psel_s, penable_s, pwrite_s, pstrb_s, pprot_s,
                               decerr_flag, timeout_flag, err_slave}), 0);
        chk({tag, "_paddr_s"}, 64'(paddr_s), 0);
        chk({tag, "_pwdata_s"}, 64'(pwdata_s), 0);
    endtask

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int w,
                        input bit se, input bit clr, input bit drop, input bit ovl);
        int  k;
        bit  hit, timed;
        int  exp_lat, cyc;
        logic [31:0] exp_rd;
        bit  exp_err;
        k       = int'(addr >> 12);
        hit     = (addr < 32'h4000) && slave_en[k % NS];
        timed   = hit && (w >= TO);
        exp_lat = !hit ? 1 : (w < TO ? 3 + w : 2 + TO);
        exp_rd  = (!hit || timed || wr) ? 32'h0 : prdata_s[k % NS];
        exp_err = !hit || timed || se;
        wait_cfg = w;
        serr_cfg = se;
        paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
        psel = 1'b1; penable = 1'b0;
        err_clr = clr && (exp_lat == 1);
        cyc = 0;
        @(posedge pclk); #1;
        cyc = 1;
        penable = 1'b1;
        err_clr = clr && (cyc == exp_lat - 1);
        forever begin
            @(negedge pclk);
            if (cyc == 1) begin
                chk("psel_s", 64'(psel_s), hit ? 64'(1 << (k % NS)) : 64'h0);
                if (hit) begin
                    chk("paddr_s", 64'(paddr_s), 64'(addr & 32'hFFF));
                    chk("wr_fields", 64'({pwrite_s, pwdata_s, pstrb_s, pprot_s}), 64'({wr, wd, st, pr}));
                    chk("penable_s_setup", 64'(penable_s), 0);
                end
                if (ovl) chk("ovl_psel", 64'(psel_s2), 64'(4'b0010));
            end
            if (cyc == 2 && hit) chk("penable_s_access", 64'(penable_s), 1);
            if (pready) break;
            if (cyc >= 40) begin
                chk("pready_wait", 0, 1);
                break;
            end
            @(posedge pclk); #1;
            cyc++;
            err_clr = clr && (cyc == exp_lat - 1);
            if (drop && cyc == 2) begin psel = 1'b0; penable = 1'b0; end
        end
        if (clr) begin m_dec = 0; m_to = 0; m_es = 0; end
        else if (!hit) m_dec = 1;
        else if (timed) begin m_to = 1; m_es = k; end
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("prdata", 64'(prdata), 64'(exp_rd));
        chk("pslverr", 64'(pslverr), 64'(exp_err));
        chk("decerr_flag", 64'(decerr_flag), 64'(m_dec));
        chk("timeout_flag", 64'(timeout_flag), 64'(m_to));
        chk("err_slave", 64'(err_slave), 64'(m_es));
        if (hit) chk("psel_s_drop", 64'({psel_s, penable_s}), 0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; err_clr = 1'b0;
        chk("pready_pulse", 64'(pready), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        paddr = '0; psel = 0; penable = 0; pwrite = 0; pwdata = '0; pstrb = '0; pprot = '0;
        err_clr = 0; slave_en = '1;
        for (int i = 0; i < NS; i++) prdata_s[i] = $urandom;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_chk("reset");
        presetn = 1'b1;
        @(posedge pclk); #1;

        prdata_s[2] = 32'hCAFE_BABE;
        xfer(32'h2010, 0, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0, 0);
        xfer(32'h1004, 1, 32'h1234_5678, 4'h3, 3'd2, 3, 0, 0, 0, 0);
        xfer(32'h8000, 0, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0, 0);
        slave_en = 4'b0111;
        xfer(32'h3000, 0, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0, 0);
        slave_en = '1;
        xfer(32'h0000, 0, 32'h0, 4'hF, 3'd0, 1000, 0, 0, 0, 0);
        xfer(32'h0004, 0, 32'h0, 4'hF, 3'd0, 1000, 0, 1, 0, 0);

        // reset during ACCESS
        wait_cfg = 1000;
        paddr = 32'h0100; pwrite = 0; psel = 1; penable = 0;
        @(posedge pclk); #1; penable = 1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        rst_chk("midrst");
        m_dec = 0; m_to = 0; m_es = 0;
        psel = 0; penable = 0;
        @(negedge pclk); presetn = 1'b1;
        @(posedge pclk); #1;
        prdata_s[3] = 32'h0BAD_F00D;
        xfer(32'h3008, 0, 32'h0, 4'hF, 3'd0, 2, 0, 0, 0, 0);
        xfer(32'h1800, 0, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0, 1);

        for (int it = 0; it < 150; it++) begin
            logic [31:0] a;
            int w;
            a = 32'($urandom_range(0, 4)) * 32'h1000 + ($urandom & 32'hFFC);
            slave_en = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3));
            for (int i = 0; i < NS; i++) prdata_s[i] = $urandom;
            xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), w,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin @(posedge pclk); #1; end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
